// File: rtl/pci_target_ready_ctrl.sv
// rtl/pci_target_ready_ctrl.sv - PCI target TRDY#/STOP# generation with wait states and burst-limit disconnect
module pci_target_ready_ctrl #(
    parameter int WAIT_STATES = 2,
    parameter int MAX_BURST   = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_n,
    input  logic             irdy_n,
    input  logic             devsel_n,
    input  logic             storage_ready,
    output logic             trdy_n,
    output logic             stop_n,
    output logic             data_xfer,
    output logic [CNT_W-1:0] xfer_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_DISCONNECT,
        S_TURNAROUND
    } state_t;

    localparam logic [3:0]       WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [CNT_W-1:0] xfer_count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             trdy_nxt, stop_nxt;

    assign data_xfer = ~trdy_n & ~irdy_n;
    assign busy      = (state != S_IDLE);
    assign count_inc = (&xfer_count) ? xfer_count : xfer_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            xfer_count <= '0;
            trdy_n     <= 1'b1;
            stop_n     <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            xfer_count <= xfer_count_nxt;
            trdy_n     <= trdy_nxt;
            stop_n     <= stop_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        xfer_count_nxt = xfer_count;
        trdy_nxt       = 1'b1;
        stop_nxt       = 1'b1;
        case (state)
            S_IDLE: begin
                if (!devsel_n) begin
                    xfer_count_nxt = '0;
                    if (WAIT_STATES == 0 && storage_ready) begin
                        state_nxt = S_DATA;
                        trdy_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (devsel_n || (frame_n && irdy_n)) begin
                    state_nxt = S_TURNAROUND;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else if (storage_ready) begin
                    state_nxt = S_DATA;
                    trdy_nxt  = 1'b0;
                end
            end
            S_DATA: begin
                // An aborted phase that completed on the same edge is still counted
                if (data_xfer) begin
                    xfer_count_nxt = count_inc;
                end
                if (devsel_n) begin
                    state_nxt = S_TURNAROUND;
                end else if (data_xfer && frame_n) begin
                    state_nxt = S_TURNAROUND;
                end else if (data_xfer && count_inc == BURST_LIM) begin
                    state_nxt = S_DISCONNECT;
                    stop_nxt  = 1'b0;
                end else if (!trdy_n && irdy_n) begin
                    // Once asserted, TRDY# must stay low until the master completes the phase
                    trdy_nxt = 1'b0;
                end else begin
                    trdy_nxt = ~storage_ready;
                end
            end
            S_DISCONNECT: begin
                if (devsel_n || frame_n) begin
                    state_nxt = S_TURNAROUND;
                end else begin
                    stop_nxt = 1'b0;
                end
            end
            S_TURNAROUND: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pci_target_ready_ctrl.sv
// tb/tb_pci_target_ready_ctrl.sv - self-checking bench for pci_target_ready_ctrl
module tb_pci_target_ready_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_n, irdy_n, devsel_n, storage_ready;
    logic       trdy_n_w [3];
    logic       stop_n_w [3];
    logic       xfer_w   [3];
    logic       busy_w   [3];
    logic [7:0] cnt_w    [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pci_target_ready_ctrl #(.WAIT_STATES(2), .MAX_BURST(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_ready(storage_ready), .trdy_n(trdy_n_w[0]), .stop_n(stop_n_w[0]),
        .data_xfer(xfer_w[0]), .xfer_count(cnt_w[0]), .busy(busy_w[0]));

    pci_target_ready_ctrl #(.WAIT_STATES(0), .MAX_BURST(4), .CNT_W(8)) u_ws0 (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_ready(storage_ready), .trdy_n(trdy_n_w[1]), .stop_n(stop_n_w[1]),
        .data_xfer(xfer_w[1]), .xfer_count(cnt_w[1]), .busy(busy_w[1]));

    pci_target_ready_ctrl #(.WAIT_STATES(3), .MAX_BURST(4), .CNT_W(8)) u_ws3 (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .devsel_n(devsel_n),
        .storage_ready(storage_ready), .trdy_n(trdy_n_w[2]), .stop_n(stop_n_w[2]),
        .data_xfer(xfer_w[2]), .xfer_count(cnt_w[2]), .busy(busy_w[2]));

    // Transaction-level view of one target: claimed, waiting, moving data, or stopping
    typedef struct {
        int ws;
        int mb;
        bit in_txn;
        bit tar;
        bit data;
        bit trdy;
        bit stop;
        int k;
        int count;
    } mdl_t;

    mdl_t m [3];

    typedef struct {
        logic       fr, ir, dv, sr;
        logic       trdy_n, stop_n, busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic mdl_t end_txn(mdl_t s);
        mdl_t n = s;
        n.in_txn = 0; n.tar = 1; n.data = 0; n.trdy = 0; n.stop = 0;
        return n;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, logic fr, logic ir, logic dv, logic sr);
        mdl_t n = s;
        bit   xfer = s.trdy && !ir;
        if (s.tar) begin
            n.tar = 0;
        end else if (!s.in_txn) begin
            if (!dv) begin
                n.in_txn = 1; n.count = 0; n.k = 0;
                if (s.ws == 0 && sr) begin n.data = 1; n.trdy = 1; end
            end
        end else begin
            if (xfer && n.count < 255) n.count = n.count + 1;
            if (dv) n = end_txn(n);
            else if (s.stop) begin
                if (fr) n = end_txn(n);
            end else if (!s.data) begin
                n.k = s.k + 1;
                if (fr && ir) n = end_txn(n);
                else if (n.k >= s.ws && sr) begin n.data = 1; n.trdy = 1; end
            end else if (xfer && fr) n = end_txn(n);
            else if (xfer && n.count == s.mb) begin n.data = 0; n.trdy = 0; n.stop = 1; end
            else if (!(s.trdy && ir)) n.trdy = sr;
        end
        return n;
    endfunction

    task automatic model_reset();
        int wsv [3] = '{2, 0, 3};
        for (int i = 0; i < 3; i++) begin
            m[i] = '{ws: wsv[i], mb: 4, in_txn: 0, tar: 0, data: 0, trdy: 0, stop: 0, k: 0, count: 0};
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(logic fr, logic ir, logic dv, logic sr);
        frame_n = fr; irdy_n = ir; devsel_n = dv; storage_ready = sr;
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = mdl_next(m[i], frame_n, irdy_n, devsel_n, storage_ready);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model trdy_n[%0d]", i), 32'(trdy_n_w[i]), 32'(!m[i].trdy));
            chk($sformatf("model stop_n[%0d]", i), 32'(stop_n_w[i]), 32'(!m[i].stop));
            chk($sformatf("model busy[%0d]", i), 32'(busy_w[i]), 32'(m[i].in_txn || m[i].tar));
            chk($sformatf("model xfer_count[%0d]", i), 32'(cnt_w[i]), 32'(m[i].count));
            chk($sformatf("model data_xfer[%0d]", i), 32'(xfer_w[i]), 32'(m[i].trdy && !irdy_n));
            chk($sformatf("never both low[%0d]", i), 32'(trdy_n_w[i] | stop_n_w[i]), 32'd1);
        end
    endtask

    task automatic idle(int n);
        drive(1, 1, 1, 1);
        for (int i = 0; i < n; i++) step();
    endtask

    function automatic vec_t mk(logic fr, logic ir, logic dv, logic sr,
                                logic tn, logic sn, logic b, logic [7:0] c);
        vec_t v;
        v.fr = fr; v.ir = ir; v.dv = dv; v.sr = sr;
        v.trdy_n = tn; v.stop_n = sn; v.busy = b; v.cnt = c;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1, 1, 1, 1);
        model_reset();
        @(negedge clk);
        chk("reset trdy_n", 32'(trdy_n_w[0]), 32'd1);
        chk("reset stop_n", 32'(stop_n_w[0]), 32'd1);
        chk("reset busy", 32'(busy_w[0]), 32'd0);
        chk("reset xfer_count", 32'(cnt_w[0]), 32'd0);
        rst = 1'b0;

        // WAIT_STATES=2: single transfer, then a burst that hits the MAX_BURST disconnect
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 4));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 4));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 4));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 4));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0, 4));
        foreach (tbl[i]) begin
            drive(tbl[i].fr, tbl[i].ir, tbl[i].dv, tbl[i].sr);
            step();
            chk($sformatf("tbl%0d trdy_n", i), 32'(trdy_n_w[0]), 32'(tbl[i].trdy_n));
            chk($sformatf("tbl%0d stop_n", i), 32'(stop_n_w[0]), 32'(tbl[i].stop_n));
            chk($sformatf("tbl%0d busy", i), 32'(busy_w[0]), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d xfer_count", i), 32'(cnt_w[0]), 32'(tbl[i].cnt));
        end

        // Decoder abort during DATA with the master waiting
        idle(2);
        drive(0, 0, 0, 1);
        step(); step(); step(); step();
        chk("abort pre count", 32'(cnt_w[0]), 32'd1);
        drive(0, 1, 1, 1);
        step();
        chk("abort trdy_n", 32'(trdy_n_w[0]), 32'd1);
        chk("abort busy", 32'(busy_w[0]), 32'd1);
        chk("abort count", 32'(cnt_w[0]), 32'd1);
        idle(1);
        chk("abort idle busy", 32'(busy_w[0]), 32'd0);
        chk("abort idle count", 32'(cnt_w[0]), 32'd1);

        // WAIT_STATES=0 with two back-end wait phases
        idle(3);
        drive(0, 0, 0, 1);
        step();
        chk("ws0 first trdy_n", 32'(trdy_n_w[1]), 32'd0);
        storage_ready = 0;
        step();
        chk("ws0 wait1 trdy_n", 32'(trdy_n_w[1]), 32'd1);
        chk("ws0 wait1 data_xfer", 32'(xfer_w[1]), 32'd0);
        step();
        chk("ws0 wait2 trdy_n", 32'(trdy_n_w[1]), 32'd1);
        chk("ws0 wait2 data_xfer", 32'(xfer_w[1]), 32'd0);
        storage_ready = 1;
        step();
        chk("ws0 resume trdy_n", 32'(trdy_n_w[1]), 32'd0);
        chk("ws0 resume data_xfer", 32'(xfer_w[1]), 32'd1);
        frame_n = 1;
        step();
        chk("ws0 last count", 32'(cnt_w[1]), 32'd2);
        idle(3);

        // WAIT_STATES=3 with storage held off until clock 6
        drive(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("ws3 hold%0d trdy_n", i), 32'(trdy_n_w[2]), 32'd1);
        end
        storage_ready = 1;
        step();
        chk("ws3 release trdy_n", 32'(trdy_n_w[2]), 32'd0);
        frame_n = 1;
        step();
        idle(3);

        // Asynchronous reset mid-burst with xfer_count=2
        drive(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step();
        chk("pre-reset trdy_n", 32'(trdy_n_w[0]), 32'd0);
        chk("pre-reset count", 32'(cnt_w[0]), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async trdy_n", 32'(trdy_n_w[0]), 32'd1);
        chk("async stop_n", 32'(stop_n_w[0]), 32'd1);
        chk("async busy", 32'(busy_w[0]), 32'd0);
        chk("async count", 32'(cnt_w[0]), 32'd0);
        model_reset();
        drive(1, 1, 1, 1);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Random traffic against the transaction model
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 19) < 2), ($urandom_range(0, 3) != 0));
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pci_target_ready_ctrl.md
Name: pci_target_ready_ctrl

Overview:
Parametrised PCI target-ready controller for the slave data path. It drives trdy_n and stop_n for one target once the address decoder has claimed the cycle with devsel_n. It adds three things to the basic ready generation: programmable initial wait states, per-phase wait insertion from the storage back end, and burst-limit disconnect with STOP. It sits between the devsel decoder, the PCI pins and the storage control logic.

Parameters:
WAIT_STATES, 2, minimum clocks between the devsel_n-low sample edge and the first trdy_n low (0 to 15).
MAX_BURST, 4, data phases accepted per transaction before target disconnect (1 to 2**CNT_W-1).
CNT_W, 8, width of the transfer counter.

Ports:
clk  input  1  PCI clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
frame_n  input  1  PCI FRAME#, active low.
irdy_n  input  1  PCI IRDY#, active low.
devsel_n  input  1  decoder claim, active low.
storage_ready  input  1  1 = storage can complete the current data phase.
trdy_n  output  1  PCI TRDY#, registered, active low.
stop_n  output  1  PCI STOP#, registered, active low.
data_xfer  output  1  combinational; equals (~trdy_n & ~irdy_n); marks a completed data phase at the next edge.
xfer_count  output  CNT_W  data phases completed in the current or last transaction.
busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE, trdy_n=1, stop_n=1, xfer_count=0, wait counter=0. Outputs are forced immediately, not at the next edge.
- States: IDLE, WAIT, DATA, DISCONNECT, TURNAROUND. trdy_n and stop_n are registered from the next state.
- IDLE:
  - On an edge with devsel_n=0, xfer_count clears to 0.
  - If WAIT_STATES=0 and storage_ready=1: go to DATA with trdy_n=0.
  - Otherwise: go to WAIT with cnt=max(WAIT_STATES-1,0).
- WAIT:
  - If cnt!=0: cnt decrements each edge.
  - If cnt==0 and storage_ready=1: go to DATA with trdy_n=0.
  - If cnt==0 and storage_ready=0: stay in WAIT with trdy_n=1.
  - Net effect: trdy_n first falls exactly WAIT_STATES edges after the sampling edge, later if storage_ready=0.
- DATA, each edge:
  - A transfer occurs when trdy_n=0 and irdy_n=0. On a transfer, xfer_count increments, saturating at all-ones.
  - Transfer with frame_n=1 (last phase): go to TURNAROUND.
  - Transfer with frame_n=0 and the incremented xfer_count == MAX_BURST: go to DISCONNECT with trdy_n=1, stop_n=0. This is a disconnect without data on the next phase.
  - Otherwise trdy_n is set to ~storage_ready, so the back end inserts wait states per phase. trdy_n stays low while irdy_n=1 (the master's wait).
- DISCONNECT: stop_n=0 and trdy_n=1 are held until frame_n=1 is sampled, then go to TURNAROUND.
- TURNAROUND:
  - Lasts exactly one clock with trdy_n=1 and stop_n=1, then returns to IDLE.
  - xfer_count holds its value until the next claim.
- devsel_n=1 sampled in WAIT, DATA or DISCONNECT (decoder abort): go to TURNAROUND next edge. trdy_n and stop_n deassert at that edge. Abort has priority over a simultaneous transfer, and that transfer is still counted.
- Master abort in WAIT (frame_n=1 and irdy_n=1): go to TURNAROUND.
- trdy_n and stop_n are never both low.
- rst asserted mid-burst: all outputs return to their reset values asynchronously, and the transaction is dropped.

Test Plan:
- Reset mid-DATA (trdy_n=0, xfer_count=2), pulse rst -> trdy_n=1, stop_n=1, busy=0 and xfer_count=0 before the next clk edge.
- WAIT_STATES=2, storage_ready=1, devsel_n low at edge E0 -> trdy_n low after E2. With irdy_n=0 and frame_n rising with the first transfer: one transfer, xfer_count=1, TURNAROUND, then IDLE after E4.
- WAIT_STATES=0, devsel_n low with storage_ready=1 -> trdy_n low after the sampling edge. Then drive storage_ready=0 for 2 clocks mid-burst -> trdy_n high for exactly those 2 phases and data_xfer=0 during them.
- MAX_BURST=4, frame_n held low, irdy_n=0, storage_ready=1 -> 4 data_xfer pulses, xfer_count=4, then stop_n=0 and trdy_n=1. stop_n holds until frame_n=1, goes high one clock later, and busy then drops.
- WAIT_STATES=3, storage_ready=0 throughout -> trdy_n stays 1 indefinitely. Raise storage_ready at clock 6 -> trdy_n low after that edge.
- Decoder abort: devsel_n goes high during DATA with irdy_n=1 -> TURNAROUND, trdy_n=1 next edge, xfer_count unchanged, IDLE after one further clock.
